maxpool_sa_writer: RTL

//  2x2/stride-2 max-pool stage between conv ReLU output and the SA data buffer. Consumes one
//  8-bit conv pixel per valid cycle (channel-major, then row-major) and writes pooled bytes

---
 rtl/pool_pkg.sv | 37 +++
 rtl/maxpool_sa_writer_if.sv | 33 +++
 rtl/pool_linebuf.sv | 38 +++
 rtl/maxpool_sa_writer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared geometry, finish codes and FSM encoding for the max-pool writer.
package pool_pkg;

    // Layer geometry: conv output width/height and channel count per layer
    localparam int W0 = 28;
    localparam int C0 = 6;
    localparam int W1 = 10;
    localparam int C1 = 16;

    // SA data buffer write-pointer width
    localparam int PTR_W = 14;

    // Line buffer holds one pooled row's worth of horizontal maxima
    localparam int LB_DEPTH = W0 / 2;
    localparam int LB_AW    = 4;

    // Counter widths sized for the larger layer (col/row up to 27, ch up to 15)
    localparam int CNT_W = 5;
    localparam int CH_W  = 4;

    // Finish codes sent to the DMA start input
    localparam logic [1:0] SA_START = 2'b01;
    localparam logic [1:0] FC_START = 2'b10;

    // FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Unsigned max; ties resolve to the first operand (either is correct)
    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_sa_writer_if.sv
// Pixel stream in and SA data buffer write bus out of the max-pool writer.
//
// Handshake: there is no ready in either direction. A pixel is consumed on
// every rising clk edge where in_valid_i is high while the writer is running,
// and the buffer must commit every cycle where sa_data_wren_o is high.
interface maxpool_sa_writer_if;
    import pool_pkg::*;

    logic             in_valid_i;
    logic [7:0]       in_data_i;
    logic             sa_data_wren_o;
    logic [PTR_W-1:0] sa_data_wrptr_o;
    logic [7:0]       sa_data_wdata_o;

    // Writer side
    modport master (
        input  in_valid_i,
        input  in_data_i,
        output sa_data_wren_o,
        output sa_data_wrptr_o,
        output sa_data_wdata_o
    );

    // Environment side: conv producer plus SA data buffer
    modport slave (
        output in_valid_i,
        output in_data_i,
        input  sa_data_wren_o,
        input  sa_data_wrptr_o,
        input  sa_data_wdata_o
    );

endinterface

// File: rtl/pool_linebuf.sv
// Line buffer of horizontal pair maxima from the even row of a 2x2 window row.
module pool_linebuf
    import pool_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [LB_AW-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic [LB_AW-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [LB_DEPTH];
    logic [7:0] mem_d [LB_DEPTH];

    // Next contents: single write port
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Storage; cleared on reset so no stale data survives an abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LB_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool_sa_writer.sv
// 2x2 stride-2 max-pool between conv ReLU output and the SA data buffer.
// Pixels arrive channel-major then row-major; pooled bytes are written to
// consecutive buffer addresses and a finish code is pulsed to the DMA after
// the last byte is committed.
module maxpool_sa_writer
    import pool_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       nth_conv_i,
    input  logic                       dst_fc_i,
    maxpool_sa_writer_if.master        bus,
    output logic                       busy_o,
    output logic [1:0]                 start_o,
    output state_t                     dbg_state_o
);

    state_t           state_q, state_d;
    logic             nth_q, nth_d;
    logic             dst_q, dst_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [7:0]       h_q, h_d;
    logic             wren_q, wren_d;
    logic [PTR_W-1:0] wrptr_q, wrptr_d;
    logic [7:0]       wdata_q, wdata_d;

    logic             accept;
    logic [CNT_W-1:0] w_max;
    logic [CH_W-1:0]  ch_max;
    logic [7:0]       px;
    logic [7:0]       pair_max;
    logic [7:0]       lb_rdata;
    logic             lb_we;
    logic [LB_AW-1:0] lb_addr;

    assign px       = bus.in_data_i;
    assign accept   = (state_q == ST_RUN) && bus.in_valid_i;
    assign w_max    = nth_q ? CNT_W'(W1 - 1) : CNT_W'(W0 - 1);
    assign ch_max   = nth_q ? CH_W'(C1 - 1) : CH_W'(C0 - 1);
    assign pair_max = max8(h_q, px);
    assign lb_addr  = col_q[CNT_W-1:1];

    pool_linebuf u_linebuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (lb_we),
        .waddr_i (lb_addr),
        .wdata_i (pair_max),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    // FSM, position counters, pooling datapath and write-port next state
    always_comb begin
        state_d = state_q;
        nth_d   = nth_q;
        dst_d   = dst_q;
        col_d   = col_q;
        row_d   = row_q;
        ch_d    = ch_q;
        h_d     = h_q;
        lb_we   = 1'b0;
        wren_d  = 1'b0;
        wdata_d = wdata_q;
        // Pointer steps once the write it addressed has been presented
        wrptr_d = wren_q ? wrptr_q + 1'b1 : wrptr_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    nth_d   = nth_conv_i;
                    dst_d   = dst_fc_i;
                    col_d   = '0;
                    row_d   = '0;
                    ch_d    = '0;
                    wrptr_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    // Even column: remember left pixel of the horizontal pair
                    if (!col_q[0]) begin
                        h_d = px;
                    end else if (!row_q[0]) begin
                        lb_we = 1'b1;
                    end else begin
                        wren_d  = 1'b1;
                        wdata_d = max8(lb_rdata, pair_max);
                    end

                    if (col_q == w_max) begin
                        col_d = '0;
                        if (row_q == w_max) begin
                            row_d = '0;
                            if (ch_q == ch_max) begin
                                ch_d    = '0;
                                state_d = ST_FLUSH;
                            end else begin
                                ch_d = ch_q + 1'b1;
                            end
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            // The final pooled byte is on the write port during this cycle
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            nth_q   <= 1'b0;
            dst_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            h_q     <= '0;
            wren_q  <= 1'b0;
            wrptr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            nth_q   <= nth_d;
            dst_q   <= dst_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ch_q    <= ch_d;
            h_q     <= h_d;
            wren_q  <= wren_d;
            wrptr_q <= wrptr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.sa_data_wren_o  = wren_q;
    assign bus.sa_data_wrptr_o = wrptr_q;
    assign bus.sa_data_wdata_o = wdata_q;
    assign busy_o              = (state_q != ST_IDLE);
    assign start_o             = (state_q == ST_DONE) ? (dst_q ? FC_START : SA_START) : 2'b00;
    assign dbg_state_o         = state_q;

endmodule
